mul_share_sched: RTL and testbench

Round-robin scheduler that shares one pipelined unsigned fixed-point multiplier among `NUM_REQ` requesters. It accepts at most one operand pair per cycle and drives the multiplier's `valid/multiplicand/multiplier` inputs. It tracks the requester ID of every in-flight operation in a tag FIFO and routes each product back to its originator on the multiplier's `ready` pulse. It sits between the systolic-array PE request ports and a single multiplier instance.

---
 rtl/mul_share_sched_if.sv | 33 +++
 rtl/mul_share_sched.sv | 140 ++++++++++++++
 tb/tb_mul_share_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_sched_if.sv
// rtl/mul_share_sched_if.sv - requester and multiplier-side bus of mul_share_sched
interface mul_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*WIDTH_A-1:0] req_a;
  logic [NUM_REQ*WIDTH_B-1:0] req_b;
  logic [NUM_REQ-1:0]         req_ready;

  logic                       mul_valid;
  logic [WIDTH_A-1:0]         mul_a;
  logic [WIDTH_B-1:0]         mul_b;
  logic                       mul_done;
  logic [WIDTH_A+WIDTH_B-1:0] mul_product;

  logic [NUM_REQ-1:0]         resp_valid;
  logic [WIDTH_A+WIDTH_B-1:0] resp_product;
  logic [IDW-1:0]             resp_id;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_product,
    output req_ready, mul_valid, mul_a, mul_b, resp_valid, resp_product, resp_id
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_product,
    input  req_ready, mul_valid, mul_a, mul_b, resp_valid, resp_product, resp_id
  );
endinterface

// File: rtl/mul_share_sched.sv
// rtl/mul_share_sched.sv - round-robin sharing of one pipelined multiplier
// among NUM_REQ requesters, with a tag FIFO routing products back in order.
module mul_share_sched #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int TAG_DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  mul_share_sched_if.slave       bus,
  output logic                   busy,
  output logic                   err
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW  = $clog2(TAG_DEPTH);
  localparam logic [IDW:0] NREQ     = (IDW+1)'(NUM_REQ);
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(TAG_DEPTH);
  localparam logic [AW:0]  CNT_ALMT = (AW+1)'(TAG_DEPTH - 1);
  localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [IDW-1:0]     last;
  logic [IDW-1:0]     grant_id;
  logic [IDW:0]       cand;
  logic               found;
  logic               can_grant;
  logic               accept;
  logic [NUM_REQ-1:0] ready_vec;
  logic [IDW-1:0]     tag_q;

  logic [IDW-1:0]     tag_mem [TAG_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               empty;
  logic               push_ok;
  logic               pop_ok;
  logic [IDW-1:0]     head;
  logic [NUM_REQ-1:0] head_onehot;

  // Search starts one past the last grant and wraps modulo NUM_REQ.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (IDW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found    = 1'b1;
        grant_id = cand[IDW-1:0];
      end
    end
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // An issue already in mul_valid will push next edge, so it counts as occupancy.
  assign can_grant = en & ~rst & ~full & ~((count == CNT_ALMT) & bus.mul_valid);
  assign accept    = found & can_grant;

  always_comb begin
    ready_vec = '0;
    if (accept) ready_vec[grant_id] = 1'b1;
  end

  assign bus.req_ready = ready_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mul_valid <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      tag_q         <= '0;
      last          <= IDW'(NUM_REQ - 1);
    end else begin
      bus.mul_valid <= accept;
      if (accept) begin
        bus.mul_a <= bus.req_a[grant_id*WIDTH_A +: WIDTH_A];
        bus.mul_b <= bus.req_b[grant_id*WIDTH_B +: WIDTH_B];
        tag_q     <= grant_id;
        last      <= grant_id;
      end
    end
  end

  // Pushing into a full FIFO is only legal when a pop frees a slot the same edge.
  assign pop_ok  = bus.mul_done & ~empty;
  assign push_ok = bus.mul_valid & (~full | pop_ok);
  assign head    = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) tag_mem[wr_ptr] <= tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if ((bus.mul_done & empty) | (bus.mul_valid & full & ~pop_ok)) err <= 1'b1;
    end
  end

  always_comb begin
    head_onehot       = '0;
    head_onehot[head] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid   <= '0;
      bus.resp_product <= '0;
      bus.resp_id      <= '0;
    end else begin
      bus.resp_valid <= '0;
      if (pop_ok) begin
        bus.resp_valid   <= head_onehot;
        bus.resp_product <= bus.mul_product;
        bus.resp_id      <= head;
      end
    end
  end

  assign busy = bus.mul_valid | ~empty;

endmodule

// File: tb/tb_mul_share_sched.sv
// tb/tb_mul_share_sched.sv - bench for mul_share_sched with a latency/queue reference model
module tb_mul_share_sched;
  localparam int N  = 4;
  localparam int WA = 16;
  localparam int WB = 16;
  localparam int TD = 32;
  localparam int PW = WA + WB;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic busy;
  logic err;
  logic inj_done;
  logic [PW-1:0] inj_prod;

  mul_share_sched_if #(.NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB)) bus ();

  mul_share_sched #(.NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .TAG_DEPTH(TD)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: fixed latency of WB cycles, reset together with the scheduler.
  logic [WB-1:0] pv;
  logic [PW-1:0] pp [WB];
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv    <= {pv[WB-2:0], bus.mul_valid};
      pp[0] <= PW'(bus.mul_a) * PW'(bus.mul_b);
      for (int k = 1; k < WB; k++) pp[k] <= pp[k-1];
    end
  end
  assign bus.mul_done    = pv[WB-1] | inj_done;
  assign bus.mul_product = inj_done ? inj_prod : pp[WB-1];

  int total, bad;
  int cyc;
  int m_last;
  logic m_err, m_mv;
  logic [WA-1:0] m_a;
  logic [WB-1:0] m_b;
  logic [PW-1:0] m_rp;
  int m_rid;
  int q_id[$];
  logic [PW-1:0] q_p[$];
  int q_due[$];
  int acc_id, acc_cyc, n_resp, resp_cyc;
  logic [PW-1:0] resp_prod;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_id.delete(); q_p.delete(); q_due.delete();
    m_last = N - 1; m_err = 1'b0; m_mv = 1'b0;
    m_a = '0; m_b = '0; m_rp = '0; m_rid = 0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, bus.req_ready, 0);
    chk({p, "_mul_valid"}, bus.mul_valid, 0);
    chk({p, "_mul_a"}, bus.mul_a, 0);
    chk({p, "_mul_b"}, bus.mul_b, 0);
    chk({p, "_resp_valid"}, bus.resp_valid, 0);
    chk({p, "_resp_product"}, bus.resp_product, 0);
    chk({p, "_resp_id"}, bus.resp_id, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err, 0);
  endtask

  task automatic new_op(input int i);
    bus.req_a[i*WA +: WA] = WA'($urandom);
    bus.req_b[i*WB +: WB] = WB'($urandom);
  endtask

  // One clock cycle: check the grant, predict the outcome, then check registered outputs.
  task automatic tick();
    int gid, fifo_cnt, idx;
    bit blk, set_err, busy_exp;
    logic [N-1:0] er, ev;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    a = '0; b = '0;
    #1;
    fifo_cnt = q_due.size() - (m_mv ? 1 : 0);
    blk = (fifo_cnt >= TD) || (fifo_cnt == TD - 1 && m_mv);
    gid = -1;
    er = '0;
    if (en && !blk)
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (gid < 0 && bus.req_valid[idx]) gid = idx;
      end
    if (gid >= 0) er[gid] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    acc_id = gid;
    set_err = inj_done && fifo_cnt == 0;
    if (gid >= 0) begin
      a = bus.req_a[gid*WA +: WA];
      b = bus.req_b[gid*WB +: WB];
      q_id.push_back(gid);
      q_p.push_back(PW'(a) * PW'(b));
      q_due.push_back(cyc + 2 + WB);
      m_last = gid;
      acc_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    m_mv = (gid >= 0);
    if (m_mv) begin m_a = a; m_b = b; end
    if (set_err) m_err = 1'b1;
    @(negedge clk);
    chk("mul_valid", bus.mul_valid, m_mv);
    chk("mul_a", bus.mul_a, m_a);
    chk("mul_b", bus.mul_b, m_b);
    ev = '0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      ev[q_id[0]] = 1'b1;
      m_rid = q_id[0];
      m_rp = q_p[0];
      void'(q_id.pop_front()); void'(q_p.pop_front()); void'(q_due.pop_front());
    end
    if (bus.resp_valid != '0) begin
      n_resp++;
      resp_cyc = cyc;
      resp_prod = bus.resp_product;
    end
    chk("resp_valid", bus.resp_valid, ev);
    chk("resp_id", bus.resp_id, m_rid);
    chk("resp_product", bus.resp_product, m_rp);
    busy_exp = q_due.size() > 0 && q_due[q_due.size()-1] > cyc;
    chk("busy", busy, busy_exp);
    chk("err", err, m_err);
  endtask

  initial begin
    int got;
    total = 0; bad = 0; cyc = 0; n_resp = 0; acc_id = -1; acc_cyc = 0;
    resp_cyc = 0; resp_prod = '0;
    rst = 1'b1; en = 1'b0; inj_done = 1'b0; inj_prod = '0;
    bus.req_valid = '1; bus.req_a = '0; bus.req_b = '0;
    en = 1'b1;
    model_reset();
    @(negedge clk);
    chk_reset("rst0");
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;

    // Single request from requester 2.
    bus.req_valid = 4'b0100;
    bus.req_a[2*WA +: WA] = 16'h1234;
    bus.req_b[2*WB +: WB] = 16'h0010;
    tick();
    chk("single_grant", acc_id, 2);
    got = acc_cyc;
    bus.req_valid = '0;
    for (int t = 0; t < 20; t++) tick();
    chk("single_latency", resp_cyc - got, WB + 2);
    chk("single_product", resp_prod, 32'h0001_2340);

    // All requesters continuously valid.
    for (int i = 0; i < N; i++) new_op(i);
    bus.req_valid = '1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (acc_id >= 0) new_op(acc_id);
    end
    bus.req_valid = '0;
    for (int t = 0; t < 20; t++) tick();

    // Fairness: 1 and 3 always valid, 0 asserts once.
    new_op(1); new_op(3);
    bus.req_valid = 4'b1010;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (acc_id >= 0) new_op(acc_id);
    end
    new_op(0);
    bus.req_valid[0] = 1'b1;
    got = -1;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (acc_id == 0 && got < 0) begin got = t + 1; bus.req_valid[0] = 1'b0; end
      else if (acc_id >= 0) new_op(acc_id);
    end
    chk("fair_latency", (got >= 1 && got <= 3), 1);
    for (int t = 0; t < 6; t++) begin
      tick();
      if (acc_id >= 0) new_op(acc_id);
    end
    bus.req_valid = '0;
    for (int t = 0; t < 20; t++) tick();

    // Randomized requests and enable.
    for (int t = 0; t < 200; t++) begin
      en = ($urandom_range(0, 99) < 85);
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) begin bus.req_valid[i] = 1'b1; new_op(i); end
        end else if ($urandom_range(0, 9) == 0) bus.req_valid[i] = 1'b0;
      end
      tick();
      if (acc_id >= 0) bus.req_valid[acc_id] = 1'b0;
    end
    en = 1'b1;
    bus.req_valid = '0;
    for (int t = 0; t < 22; t++) tick();

    // Drain via en with 10 operations in flight.
    for (int i = 0; i < N; i++) new_op(i);
    bus.req_valid = '1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (acc_id >= 0) new_op(acc_id);
    end
    en = 1'b0;
    n_resp = 0;
    for (int t = 0; t < 22; t++) tick();
    chk("drain_responses", n_resp, 10);
    bus.req_valid = '0;
    en = 1'b1;

    // Error injection while idle.
    inj_prod = 32'h0000_DEAD;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("err_set", err, 1);
    for (int t = 0; t < 5; t++) tick();

    // Reset mid-stream with 5 operations in flight.
    for (int i = 0; i < N; i++) new_op(i);
    bus.req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (acc_id >= 0) new_op(acc_id);
    end
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b0101;
    new_op(0); new_op(2);
    tick();
    chk("post_rst_first", acc_id, 0);
    if (acc_id >= 0) bus.req_valid[acc_id] = 1'b0;
    tick();
    chk("post_rst_second", acc_id, 2);
    if (acc_id >= 0) bus.req_valid[acc_id] = 1'b0;
    bus.req_valid = '0;
    for (int t = 0; t < 20; t++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
